// File: rtl/jtdsp16_hostif.sv
// Host-to-DSP16 parallel port mailbox: 8-bit host writes build 16-bit words queued for the DSP.
// DSP output words are captured for the host. Optional macro JTDSP16_HOSTIF_AUTOACK_EN lets the DSP flush the queue.
module jtdsp16_hostif #(
   parameter int AW = 3
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic [1:0]  host_addr,
   input  logic [7:0]  host_din,
   input  logic        host_we,
   input  logic        host_rd,
   output logic [7:0]  host_dout,
   input  logic [15:0] dsp_pbus_out,
   input  logic        pods_n,
   input  logic        pids_n,
   input  logic        psel,
   output logic [15:0] dsp_pbus_in,
   output logic        dsp_irq
);

   localparam int DEPTH = 2**AW;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    hi_latch;
   logic [15:0]   out0, out1;
   logic          out_valid0, out_valid1;
   logic          ovf;
   logic          last_pids_n, last_pods_n;

   logic          full, empty;
   logic          push_req, push_ok, pop, pids_rise, pods_rise;
   logic          host_flush, auto_flush, flush;
   logic [3:0]    count_sat;

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign pids_rise = cen & ~last_pids_n & pids_n;
   assign pods_rise = cen & ~last_pods_n & pods_n;

   assign push_req   = host_we & (host_addr == 2'd1);
   assign host_flush = host_we & (host_addr == 2'd3);
   assign pop        = pids_rise & ~psel & ~empty;
   // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
   assign push_ok    = push_req & (~full | pop);

`ifdef JTDSP16_HOSTIF_AUTOACK_EN
   assign auto_flush = pods_rise & psel & dsp_pbus_out[15];
`else
   assign auto_flush = 1'b0;
`endif
   assign flush = host_flush | auto_flush;

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= {hi_latch, host_din};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
         if (push_req && !push_ok) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_latch <= 8'h00;
      end else if (host_we && host_addr == 2'd0) begin
         hi_latch <= host_din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_pids_n <= 1'b1;
         last_pods_n <= 1'b1;
         dsp_irq     <= 1'b0;
      end else if (cen) begin
         last_pids_n <= pids_n;
         last_pods_n <= pods_n;
         dsp_irq     <= ~empty;
      end
   end

   // Capture is ordered after the host clear so a same-cycle capture keeps the valid flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0       <= 16'h0000;
         out1       <= 16'h0000;
         out_valid0 <= 1'b0;
         out_valid1 <= 1'b0;
      end else begin
         if (host_rd && host_addr == 2'd2) out_valid0 <= 1'b0;
         if (host_rd && host_addr == 2'd3) out_valid1 <= 1'b0;
         if (pods_rise) begin
            if (psel) begin
               out1       <= dsp_pbus_out;
               out_valid1 <= 1'b1;
            end else begin
               out0       <= dsp_pbus_out;
               out_valid0 <= 1'b1;
            end
         end
      end
   end

   assign count_sat = (32'(count) > 32'd15) ? 4'd15 : 4'(count);

   always_comb begin
      dsp_pbus_in = 16'h0000;
      if (psel)        dsp_pbus_in = {ovf, full, {(13-AW){1'b0}}, count};
      else if (!empty) dsp_pbus_in = mem[rd_ptr];
   end

   always_comb begin
      host_dout = 8'h00;
      case (host_addr)
         2'd0: host_dout = {out_valid1, out_valid0, ovf, full, count_sat};
         2'd1: host_dout = out0[15:8];
         2'd2: host_dout = out0[7:0];
         2'd3: host_dout = out1[7:0];
         default: host_dout = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_jtdsp16_hostif.sv
// Bench for jtdsp16_hostif: directed scenarios followed by random traffic, all checked
// against a queue-based model of the mailbox.
module tb_jtdsp16_hostif;

   localparam int DEPTH = 8;

   logic        rst, clk, cen;
   logic [1:0]  host_addr;
   logic [7:0]  host_din;
   logic        host_we, host_rd;
   logic [7:0]  host_dout;
   logic [15:0] dsp_pbus_out;
   logic        pods_n, pids_n, psel;
   logic [15:0] dsp_pbus_in;
   logic        dsp_irq;

   int n_vec = 0;
   int n_err = 0;

   jtdsp16_hostif #(.AW(3)) dut (
      .rst(rst), .clk(clk), .cen(cen),
      .host_addr(host_addr), .host_din(host_din), .host_we(host_we), .host_rd(host_rd),
      .host_dout(host_dout), .dsp_pbus_out(dsp_pbus_out), .pods_n(pods_n), .pids_n(pids_n),
      .psel(psel), .dsp_pbus_in(dsp_pbus_in), .dsp_irq(dsp_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [15:0] q[$];
   logic [7:0]  m_hi;
   logic [15:0] m_out0, m_out1;
   bit          m_v0, m_v1, m_ovf, m_irq, m_lpids, m_lpods;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_hi = 8'h00; m_out0 = 16'h0000; m_out1 = 16'h0000;
      m_v0 = 0; m_v1 = 0; m_ovf = 0; m_irq = 0; m_lpids = 1; m_lpods = 1;
   endtask

   function automatic logic [15:0] exp_pbus();
      int v;
      if (psel) begin
         v = q.size();
         if (m_ovf) v += 32768;
         if (q.size() == DEPTH) v += 16384;
         return 16'(v);
      end
      if (q.size() == 0) return 16'h0000;
      return q[0];
   endfunction

   function automatic logic [7:0] exp_dout();
      int v;
      case (host_addr)
         2'd0: begin
            v = (q.size() > 15) ? 15 : q.size();
            if (m_v1) v += 128;
            if (m_v0) v += 64;
            if (m_ovf) v += 32;
            if (q.size() == DEPTH) v += 16;
            return 8'(v);
         end
         2'd1: return m_out0[15:8];
         2'd2: return m_out0[7:0];
         default: return m_out1[7:0];
      endcase
   endfunction

   // Apply the mailbox rules for one clock using the inputs currently driven.
   task automatic model_step();
      bit pop, prise, flush;
      logic [15:0] w;
      if (rst) return;
      pop   = cen && !m_lpids && pids_n && !psel && q.size() > 0;
      prise = cen && !m_lpods && pods_n;
      flush = host_we && host_addr == 2'd3;
`ifdef JTDSP16_HOSTIF_AUTOACK_EN
      if (prise && psel && dsp_pbus_out[15]) flush = 1;
`endif
      if (cen) m_irq = (q.size() != 0);
      w = {m_hi, host_din};
      if (flush) begin
         q.delete();
         m_ovf = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (host_we && host_addr == 2'd1) begin
            if (q.size() < DEPTH) q.push_back(w);
            else m_ovf = 1;
         end
      end
      if (host_we && host_addr == 2'd0) m_hi = host_din;
      if (host_rd && host_addr == 2'd2) m_v0 = 0;
      if (host_rd && host_addr == 2'd3) m_v1 = 0;
      if (prise) begin
         if (psel) begin m_out1 = dsp_pbus_out; m_v1 = 1; end
         else      begin m_out0 = dsp_pbus_out; m_v0 = 1; end
      end
      if (cen) begin m_lpids = pids_n; m_lpods = pods_n; end
   endtask

   task automatic cycle();
      @(negedge clk);
      chk("pbus", dsp_pbus_in, exp_pbus());
      chk("irq", {15'd0, dsp_irq}, {15'd0, m_irq});
      chk("dout", {8'd0, host_dout}, {8'd0, exp_dout()});
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
      host_we = 1; host_addr = a; host_din = d;
      cycle();
      host_we = 0;
   endtask

   task automatic push_word(input logic [15:0] w);
      host_wr(2'd0, w[15:8]);
      host_wr(2'd1, w[7:0]);
   endtask

   task automatic pids_pulse();
      pids_n = 0; cycle(); cycle();
      pids_n = 1; cycle();
   endtask

   task automatic pods_pulse(input logic [15:0] d);
      dsp_pbus_out = d;
      pods_n = 0; cycle();
      pods_n = 1; cycle();
   endtask

   task automatic rd_status(input string tag, input logic [7:0] exp);
      host_addr = 2'd0; #1;
      chk(tag, {8'd0, host_dout}, {8'd0, exp});
   endtask

   initial begin
      rst = 1; cen = 1; host_addr = 0; host_din = 0; host_we = 0; host_rd = 0;
      dsp_pbus_out = 0; pods_n = 1; pids_n = 1; psel = 0;
      model_reset();
      repeat (2) cycle();
      rst = 0;
      chk("rst_pbus", dsp_pbus_in, 16'h0000);
      chk("rst_irq", {15'd0, dsp_irq}, 16'h0000);
      rd_status("rst_status", 8'h00);

      // single word round trip
      host_wr(2'd0, 8'h12);
      host_wr(2'd1, 8'h34);
      rd_status("one_count", 8'h01);
      cycle();
      chk("one_irq", {15'd0, dsp_irq}, 16'h0001);
      chk("one_head", dsp_pbus_in, 16'h1234);
      pids_pulse();
      rd_status("one_popped", 8'h00);
      chk("one_empty_bus", dsp_pbus_in, 16'h0000);
      cycle();
      chk("one_irq_off", {15'd0, dsp_irq}, 16'h0000);

      // overflow and ordering
      for (int i = 0; i < 9; i++) push_word({8'(i), 8'(i + 8'h80)});
      rd_status("ovf_status", 8'h38);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_order", dsp_pbus_in, {8'(i), 8'(i + 8'h80)});
         pids_pulse();
      end
      rd_status("ovf_drained", 8'h20);
      host_wr(2'd3, 8'h00);
      rd_status("flush_clr", 8'h00);

      // simultaneous push and pop
      for (int i = 1; i <= 3; i++) push_word(16'hA000 + 16'(i));
      pids_n = 0; cycle();
      host_we = 1; host_addr = 2'd1; host_din = 8'h04; pids_n = 1;
      cycle();
      host_we = 0;
      rd_status("pp_count", 8'h03);
      chk("pp_head", dsp_pbus_in, 16'hA002);
      host_wr(2'd3, 8'h00);

      // DSP output capture
      pods_pulse(16'hBEEF);
      host_addr = 2'd1; #1; chk("out0_hi", {8'd0, host_dout}, 16'h00BE);
      host_addr = 2'd2; #1; chk("out0_lo", {8'd0, host_dout}, 16'h00EF);
      rd_status("out0_valid", 8'h40);
      host_rd = 1; host_addr = 2'd2; cycle(); host_rd = 0;
      rd_status("out0_clr", 8'h00);
      psel = 1;
      pods_pulse(16'h0042);
      host_addr = 2'd3; #1; chk("out1", {8'd0, host_dout}, 16'h0042);
      psel = 0;
      rd_status("out1_valid", 8'h80);

      // status view and no pop with psel=1
      push_word(16'h1111);
      push_word(16'h2222);
      psel = 1;
      pids_pulse();
      chk("psel_status", dsp_pbus_in, 16'h0002);
      pods_pulse(16'h8000);
      psel = 0;
`ifdef JTDSP16_HOSTIF_AUTOACK_EN
      rd_status("autoack", 8'h80);
`else
      rd_status("autoack", 8'h82);
`endif
      host_wr(2'd3, 8'h00);

      // reset during a strobe
      for (int i = 0; i < 4; i++) push_word(16'h3300 + 16'(i));
      pids_n = 0; cycle();
      rst = 1; #1;
      model_reset();
      chk("mid_rst_pbus", dsp_pbus_in, 16'h0000);
      chk("mid_rst_irq", {15'd0, dsp_irq}, 16'h0000);
      rd_status("mid_rst_status", 8'h00);
      host_addr = 2'd3; #1; chk("mid_rst_out1", {8'd0, host_dout}, 16'h0000);
      cycle();
      rst = 0;
      pids_n = 1; cycle();
      push_word(16'h5566);
      cycle();
      rd_status("post_rst", 8'h01);
      chk("post_rst_head", dsp_pbus_in, 16'h5566);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         int r;
         cen = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         host_addr = (r < 4) ? 2'd0 : (r < 16) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
         host_we = ($urandom_range(0, 9) < 4);
         if (host_we && host_addr == 2'd3 && $urandom_range(0, 3) != 0) host_we = 0;
         host_rd = ($urandom_range(0, 4) == 0);
         host_din = 8'($urandom);
         dsp_pbus_out = 16'($urandom);
         if ($urandom_range(0, 2) == 0) pids_n = ~pids_n;
         if ($urandom_range(0, 3) == 0) pods_n = ~pods_n;
         if ($urandom_range(0, 7) == 0) psel = ~psel;
         if ($urandom_range(0, 799) == 0) begin
            rst = 1; #1;
            model_reset();
            cycle();
            rst = 0;
         end else begin
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
